// File: rtl/fc_head_seq.sv
// Fully-connected output head: multiply-accumulates UNITS hidden values against stored
// weights, adds a bias and returns a saturated sign-magnitude Q1.FRAC_BITS prediction.
module fc_head_seq #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned UNITS      = 4,
  parameter int unsigned FRAC_BITS  = 30,
  parameter int unsigned ACC_WIDTH  = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] ht0,
  input  logic [DATA_WIDTH-1:0] ht1,
  input  logic [DATA_WIDTH-1:0] ht2,
  input  logic [DATA_WIDTH-1:0] ht3,
  input  logic                  w_wr_en,
  input  logic [2:0]            w_wr_addr,
  input  logic [DATA_WIDTH-1:0] w_wr_data,
  output logic                  wr_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] pred,
  output logic                  ovf
);

  localparam int unsigned MagW  = DATA_WIDTH - 1;
  localparam int unsigned ProdW = 2 * MagW;
  localparam int unsigned IdxW  = (UNITS > 1) ? $clog2(UNITS) : 1;
  localparam int unsigned NumHt = 4;
  localparam logic [ACC_WIDTH-1:0] MaxMag = ACC_WIDTH'((64'd1 << MagW) - 64'd1);

  typedef enum logic [1:0] {StIdle, StMac, StBias, StOut} state_e;

  state_e                      r_state;
  state_e                      w_state_d;
  logic [DATA_WIDTH-1:0]       r_ht [UNITS];
  logic [DATA_WIDTH-1:0]       r_w  [UNITS];
  logic [DATA_WIDTH-1:0]       r_bias;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic [IdxW-1:0]             r_idx;
  logic [DATA_WIDTH-1:0]       r_pred;
  logic                        r_out_valid;
  logic                        r_ovf;
  logic                        r_wr_err;

  logic [DATA_WIDTH-1:0]       w_ht_in [NumHt];
  logic [DATA_WIDTH-1:0]       w_ht_cur;
  logic [DATA_WIDTH-1:0]       w_w_cur;
  logic signed [ACC_WIDTH-1:0] w_sum;
  logic [ACC_WIDTH-1:0]        w_abs;
  logic                        w_neg;
  logic                        w_sat;
  logic [DATA_WIDTH-1:0]       w_pred_d;
  logic                        w_addr_ok;
  logic                        w_state_wr_ok;
  logic                        w_wr_take;
  logic                        w_wr_drop;

  // Sign-magnitude to two's complement; -0 folds to 0 naturally.
  function automatic logic signed [ACC_WIDTH-1:0] sm_to_tc(input logic [DATA_WIDTH-1:0] v);
    logic signed [ACC_WIDTH-1:0] mag;
    mag = $signed({{(ACC_WIDTH - MagW){1'b0}}, v[MagW-1:0]});
    return v[DATA_WIDTH-1] ? -mag : mag;
  endfunction

  // Fixed-point product, magnitude truncated toward zero before the sign is applied.
  function automatic logic signed [ACC_WIDTH-1:0] mul_sm(input logic [DATA_WIDTH-1:0] a,
                                                         input logic [DATA_WIDTH-1:0] b);
    logic [ProdW-1:0]            prod;
    logic [ProdW-1:0]            shifted;
    logic signed [ACC_WIDTH-1:0] mag;
    prod    = ProdW'(a[MagW-1:0]) * ProdW'(b[MagW-1:0]);
    shifted = prod >> FRAC_BITS;
    mag     = $signed(shifted[ACC_WIDTH-1:0]);
    return (a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1]) ? -mag : mag;
  endfunction

  assign w_ht_in[0] = ht0;
  assign w_ht_in[1] = ht1;
  assign w_ht_in[2] = ht2;
  assign w_ht_in[3] = ht3;

  assign w_ht_cur = r_ht[r_idx];
  assign w_w_cur  = r_w[r_idx];

  assign w_sum    = r_acc + sm_to_tc(r_bias);
  assign w_neg    = w_sum[ACC_WIDTH-1];
  assign w_abs    = w_neg ? $unsigned(-w_sum) : $unsigned(w_sum);
  assign w_sat    = w_abs > MaxMag;
  assign w_pred_d = w_sat ? {w_neg, {MagW{1'b1}}} : {w_neg, w_abs[MagW-1:0]};

  // Coefficients may only change while no computation is reading them.
  assign w_addr_ok     = 32'(w_wr_addr) <= UNITS;
  assign w_state_wr_ok = (r_state == StIdle) || (r_state == StOut);
  assign w_wr_take     = w_wr_en && w_addr_ok && w_state_wr_ok;
  assign w_wr_drop     = w_wr_en && !w_wr_take;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (in_valid) w_state_d = StMac;
      StMac:   if (r_idx == IdxW'(UNITS - 1)) w_state_d = StBias;
      StBias:  w_state_d = StOut;
      StOut:   if (out_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(UNITS); i++) begin
        r_ht[i] <= '0;
        r_w[i]  <= '0;
      end
      r_bias      <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_pred      <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_wr_err    <= 1'b0;
    end else begin
      r_wr_err <= w_wr_drop;
      for (int i = 0; i < int'(UNITS); i++) begin
        if (w_wr_take && (32'(w_wr_addr) == 32'(i))) r_w[i] <= w_wr_data;
      end
      if (w_wr_take && (32'(w_wr_addr) == UNITS)) r_bias <= w_wr_data;

      case (r_state)
        StIdle: begin
          if (in_valid) begin
            for (int i = 0; i < int'(UNITS); i++) begin
              if (i < int'(NumHt)) r_ht[i] <= w_ht_in[i];
            end
            r_acc <= '0;
            r_idx <= '0;
            r_ovf <= 1'b0;
          end
        end
        StMac: begin
          r_acc <= r_acc + mul_sm(w_ht_cur, w_w_cur);
          r_idx <= r_idx + 1'b1;
        end
        StBias: begin
          r_pred      <= w_pred_d;
          r_ovf       <= w_sat;
          r_out_valid <= 1'b1;
        end
        StOut: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == StIdle) && !rst;
  assign out_valid = r_out_valid;
  assign pred      = r_pred;
  assign ovf       = r_ovf;
  assign wr_err    = r_wr_err;

endmodule

// File: tb/tb_fc_head_seq.sv
// Randomised bench for fc_head_seq; expected predictions come from an arithmetic model
// over shadow copies of the coefficients.
module tb_fc_head_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ht0, ht1, ht2, ht3;
  logic        w_wr_en;
  logic [2:0]  w_wr_addr;
  logic [31:0] w_wr_data;
  logic        wr_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pred;
  logic        ovf;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m_w [4];
  logic [31:0] m_bias;
  logic [31:0] v_ht [4];

  fc_head_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ht0       (ht0),
    .ht1       (ht1),
    .ht2       (ht2),
    .ht3       (ht3),
    .w_wr_en   (w_wr_en),
    .w_wr_addr (w_wr_addr),
    .w_wr_data (w_wr_data),
    .wr_err    (wr_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pred      (pred),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Returns {ovf, pred} for v_ht against the shadow coefficients.
  function automatic logic [32:0] model();
    longint sum, am, bm, mag, a;
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      am  = longint'(v_ht[i][30:0]);
      bm  = longint'(m_w[i][30:0]);
      mag = (am * bm) >> 30;
      sum = sum + ((v_ht[i][31] ^ m_w[i][31]) ? -mag : mag);
    end
    bm  = longint'(m_bias[30:0]);
    sum = sum + (m_bias[31] ? -bm : bm);
    a   = (sum < 0) ? -sum : sum;
    if (a > 64'sd2147483647) return {1'b1, sum < 0, 31'h7FFFFFFF};
    return {1'b0, sum < 0, a[30:0]};
  endfunction

  function automatic logic [31:0] rnd_val();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: rnd_val = r;
      1: rnd_val = {r[31], r[30:0] >> $urandom_range(1, 8)};
      2: rnd_val = {r[31], 31'h0};
      default: rnd_val = {r[31], 31'h40000000 >> $urandom_range(0, 3)};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    w_wr_en   = 1'b1;
    w_wr_addr = a;
    w_wr_data = d;
    tick();
    w_wr_en   = 1'b0;
  endtask

  // Write made while the DUT is in IDLE or OUT, so the shadow follows it.
  task automatic wr_coef(input logic [2:0] a, input logic [31:0] d);
    wr(a, d);
    if (a == 3'd4) m_bias = d;
    else m_w[a[1:0]] = d;
  endtask

  task automatic drive_ht();
    ht0 = v_ht[0];
    ht1 = v_ht[1];
    ht2 = v_ht[2];
    ht3 = v_ht[3];
  endtask

  task automatic wait_out(inout int lat);
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic run(output int lat);
    drive_ht();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    wait_out(lat);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (pred !== 32'h0) $display("FAIL reset_pred got %h exp 0", pred); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b exp 0", ovf); else n_pass++;
    n_checks++; if (wr_err !== 1'b0) $display("FAIL reset_wr_err got %b exp 0", wr_err); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready got %b exp 1", in_ready); else n_pass++;
    for (int i = 0; i < 4; i++) m_w[i] = '0;
    m_bias = '0;
  endtask

  task automatic test_directed();
    int lat;
    for (int i = 0; i < 4; i++) wr_coef(3'(i), 32'h20000000);
    wr_coef(3'd4, 32'h0);
    for (int i = 0; i < 4; i++) v_ht[i] = 32'h20000000;
    run(lat);
    n_checks++; if (lat !== 5) $display("FAIL half_latency got %0d exp 5", lat); else n_pass++;
    n_checks++; if (pred !== 32'h40000000) $display("FAIL half_pred got %h exp 40000000", pred); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL half_ovf got %b exp 0", ovf); else n_pass++;
    release_out();

    wr_coef(3'd0, 32'h20000000);
    for (int i = 1; i < 4; i++) wr_coef(3'(i), 32'h0);
    wr_coef(3'd4, 32'h10000000);
    v_ht[0] = 32'hA0000000;
    for (int i = 1; i < 4; i++) v_ht[i] = 32'h0;
    run(lat);
    n_checks++; if (pred !== 32'h00000000) $display("FAIL zero_pred got %h exp 00000000", pred); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL zero_ovf got %b exp 0", ovf); else n_pass++;
    release_out();

    for (int i = 0; i < 4; i++) wr_coef(3'(i), 32'h60000000);
    wr_coef(3'd4, 32'h0);
    for (int i = 0; i < 4; i++) v_ht[i] = 32'h60000000;
    run(lat);
    n_checks++; if (pred !== 32'h7FFFFFFF) $display("FAIL sat_pos_pred got %h exp 7fffffff", pred); else n_pass++;
    n_checks++; if (ovf !== 1'b1) $display("FAIL sat_pos_ovf got %b exp 1", ovf); else n_pass++;
    release_out();

    for (int i = 0; i < 4; i++) wr_coef(3'(i), 32'hE0000000);
    run(lat);
    n_checks++; if (pred !== 32'hFFFFFFFF) $display("FAIL sat_neg_pred got %h exp ffffffff", pred); else n_pass++;
    n_checks++; if (ovf !== 1'b1) $display("FAIL sat_neg_ovf got %b exp 1", ovf); else n_pass++;
    release_out();
  endtask

  task automatic test_random();
    int          lat;
    logic [32:0] exp;
    for (int n = 0; n < 40; n++) begin
      for (int k = $urandom_range(0, 3); k > 0; k--) wr_coef(3'($urandom_range(0, 4)), rnd_val());
      for (int i = 0; i < 4; i++) v_ht[i] = rnd_val();
      exp = model();
      run(lat);
      n_checks++; if (lat !== 5) $display("FAIL rand_latency[%0d] got %0d exp 5", n, lat); else n_pass++;
      n_checks++; if (pred !== exp[31:0]) $display("FAIL rand_pred[%0d] got %h exp %h", n, pred, exp[31:0]); else n_pass++;
      n_checks++; if (ovf !== exp[32]) $display("FAIL rand_ovf[%0d] got %b exp %b", n, ovf, exp[32]); else n_pass++;
      release_out();
    end
  endtask

  task automatic test_backpressure();
    int          lat;
    logic [32:0] exp;
    logic [31:0] neww;
    for (int i = 0; i < 4; i++) v_ht[i] = rnd_val();
    exp = model();
    run(lat);
    for (int i = 0; i < 4; i++) v_ht[i] = rnd_val();
    drive_ht();
    in_valid = 1'b1;
    neww     = rnd_val();
    for (int k = 0; k < 3; k++) begin
      if (k == 0) begin
        w_wr_en = 1'b1; w_wr_addr = 3'd0; w_wr_data = neww;
      end
      tick();
      w_wr_en = 1'b0;
      n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid[%0d] got %b exp 1", k, out_valid); else n_pass++;
      n_checks++; if (pred !== exp[31:0]) $display("FAIL bp_pred[%0d] got %h exp %h", k, pred, exp[31:0]); else n_pass++;
      n_checks++; if (ovf !== exp[32]) $display("FAIL bp_ovf[%0d] got %b exp %b", k, ovf, exp[32]); else n_pass++;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d] got %b exp 0", k, in_ready); else n_pass++;
      n_checks++; if (wr_err !== 1'b0) $display("FAIL bp_wr_err[%0d] got %b exp 0", k, wr_err); else n_pass++;
    end
    m_w[0] = neww;
    exp = model();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_drop_valid got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_resume_ready got %b exp 1", in_ready); else n_pass++;
    tick();
    in_valid = 1'b0;
    lat = 0;
    wait_out(lat);
    n_checks++; if (lat !== 5) $display("FAIL bp_next_latency got %0d exp 5", lat); else n_pass++;
    n_checks++; if (pred !== exp[31:0]) $display("FAIL bp_next_pred got %h exp %h", pred, exp[31:0]); else n_pass++;
    release_out();
  endtask

  task automatic test_wr_err();
    int          lat;
    logic [32:0] exp;
    for (int i = 0; i < 4; i++) wr_coef(3'(i), rnd_val());
    wr_coef(3'd4, rnd_val());
    for (int i = 0; i < 4; i++) v_ht[i] = rnd_val();
    exp = model();
    drive_ht();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wr(3'd2, ~m_w[2]);
    n_checks++; if (wr_err !== 1'b1) $display("FAIL mac_wr_err got %b exp 1", wr_err); else n_pass++;
    tick();
    n_checks++; if (wr_err !== 1'b0) $display("FAIL mac_wr_err_pulse got %b exp 0", wr_err); else n_pass++;
    lat = 2;
    wait_out(lat);
    n_checks++; if (lat !== 5) $display("FAIL mac_wr_latency got %0d exp 5", lat); else n_pass++;
    n_checks++; if (pred !== exp[31:0]) $display("FAIL mac_wr_pred got %h exp %h", pred, exp[31:0]); else n_pass++;
    release_out();

    wr(3'd6, rnd_val());
    n_checks++; if (wr_err !== 1'b1) $display("FAIL rsv_wr_err got %b exp 1", wr_err); else n_pass++;
    tick();
    n_checks++; if (wr_err !== 1'b0) $display("FAIL rsv_wr_err_pulse got %b exp 0", wr_err); else n_pass++;
    wr_coef(3'd4, rnd_val());
    n_checks++; if (wr_err !== 1'b0) $display("FAIL ok_wr_err got %b exp 0", wr_err); else n_pass++;
    exp = model();
    run(lat);
    n_checks++; if (pred !== exp[31:0]) $display("FAIL rsv_pred got %h exp %h", pred, exp[31:0]); else n_pass++;
    release_out();
  endtask

  task automatic test_same_edge();
    int          lat;
    logic [32:0] exp;
    logic [2:0]  a;
    logic [31:0] d;
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < 4; i++) v_ht[i] = rnd_val();
      a = 3'($urandom_range(0, 4));
      d = rnd_val();
      if (a == 3'd4) m_bias = d;
      else m_w[a[1:0]] = d;
      exp = model();
      drive_ht();
      in_valid = 1'b1;
      w_wr_en = 1'b1; w_wr_addr = a; w_wr_data = d;
      tick();
      in_valid = 1'b0;
      w_wr_en  = 1'b0;
      n_checks++; if (wr_err !== 1'b0) $display("FAIL same_edge_wr_err[%0d] got %b exp 0", n, wr_err); else n_pass++;
      lat = 0;
      wait_out(lat);
      n_checks++; if (pred !== exp[31:0]) $display("FAIL same_edge_pred[%0d] got %h exp %h", n, pred, exp[31:0]); else n_pass++;
      release_out();
    end
  endtask

  task automatic test_reset_mid();
    int   lat;
    logic seen;
    for (int i = 0; i < 4; i++) begin
      wr_coef(3'(i), 32'h20000000);
      v_ht[i] = 32'h20000000;
    end
    drive_ht();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL mid_rst_in_ready got %b exp 1", in_ready); else n_pass++;
    n_checks++; if (pred !== 32'h0) $display("FAIL mid_rst_pred got %h exp 0", pred); else n_pass++;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL mid_rst_no_valid got %b exp 0", seen); else n_pass++;
    for (int i = 0; i < 4; i++) m_w[i] = '0;
    m_bias = '0;
    for (int i = 0; i < 4; i++) v_ht[i] = rnd_val();
    run(lat);
    n_checks++; if (lat !== 5) $display("FAIL mid_rst_next_latency got %0d exp 5", lat); else n_pass++;
    n_checks++; if (pred !== 32'h0) $display("FAIL mid_rst_zero_coef_pred got %h exp 0", pred); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL mid_rst_zero_coef_ovf got %b exp 0", ovf); else n_pass++;
    release_out();

    for (int i = 0; i < 4; i++) begin
      wr_coef(3'(i), 32'h60000000);
      v_ht[i] = 32'h60000000;
    end
    run(lat);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL out_rst_valid got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (pred !== 32'h0) $display("FAIL out_rst_pred got %h exp 0", pred); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL out_rst_ovf got %b exp 0", ovf); else n_pass++;
    for (int i = 0; i < 4; i++) m_w[i] = '0;
    m_bias = '0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    w_wr_en   = 1'b0;
    w_wr_addr = '0;
    w_wr_data = '0;
    ht0 = '0; ht1 = '0; ht2 = '0; ht3 = '0;
    for (int i = 0; i < 4; i++) v_ht[i] = '0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_wr_err();
    test_same_edge();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
